// File: rtl/mps_op_sequencer_if.sv
// mps_op_sequencer_if: request, feedback and status bundle
// for the MPS power-stage contactor sequencer.
interface mps_op_sequencer_if #(
    parameter int P_DC_W = 16
);
    logic              i_op_on_flag;
    logic              i_op_off_flag;
    logic              i_intl_flag;
    logic [2:0]        i_mc_aux;
    logic [P_DC_W-1:0] i_dc_link;
    logic [P_DC_W-1:0] i_prechg_lvl;
    logic [P_DC_W-1:0] i_dischg_lvl;
    logic [3:0]        o_op_on_fsm;
    logic [3:0]        o_op_off_fsm;
    logic [2:0]        o_fail_code;
    logic              o_off_tmo;
    logic              o_busy;

    modport master (
        output i_op_on_flag, i_op_off_flag, i_intl_flag, i_mc_aux,
        output i_dc_link, i_prechg_lvl, i_dischg_lvl,
        input  o_op_on_fsm, o_op_off_fsm, o_fail_code, o_off_tmo, o_busy
    );

    modport slave (
        input  i_op_on_flag, i_op_off_flag, i_intl_flag, i_mc_aux,
        input  i_dc_link, i_prechg_lvl, i_dischg_lvl,
        output o_op_on_fsm, o_op_off_fsm, o_fail_code, o_off_tmo, o_busy
    );
endinterface

// File: rtl/mps_op_sequencer.sv
// mps_op_sequencer: contactor on/off sequencer, one shared down-timer.
// Optional MPS_AUX_CHECK_EN enforces contactor aux feedback checks.
module mps_op_sequencer #(
    parameter int P_SETTLE_CNT = 50000,
    parameter int P_PRECHG_TMO = 5000000,
    parameter int P_DISCHG_TMO = 10000000,
    parameter int P_DC_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mps_op_sequencer_if.slave  bus
);

    typedef enum logic [3:0] {
        ON_IDLE   = 4'd0,
        ON_OPEN   = 4'd1,
        ON_OPEN_W = 4'd2,
        ON_PRE    = 4'd3,
        ON_PRE_W  = 4'd4,
        ON_MAIN   = 4'd5,
        ON_MAIN_W = 4'd6,
        ON_ALL    = 4'd9,
        ON_ALL_W  = 4'd10,
        ON_REL    = 4'd11,
        ON_REL_W  = 4'd12,
        ON_DONE   = 4'd14,
        ON_FAIL   = 4'd15
    } on_st_e;

    typedef enum logic [3:0] {
        OFF_IDLE = 4'd0,
        OFF_OPEN = 4'd1,
        OFF_DIS  = 4'd2,
        OFF_END  = 4'd3
    } off_st_e;

    localparam logic [31:0] SETTLE_LD = 32'(P_SETTLE_CNT - 1);
    localparam logic [31:0] PRECHG_LD = 32'(P_PRECHG_TMO - 1);
    localparam logic [31:0] DISCHG_LD = 32'(P_DISCHG_TMO - 1);

`ifdef MPS_AUX_CHECK_EN
    localparam bit AUX_CHK = 1'b1;
`else
    localparam bit AUX_CHK = 1'b0;
`endif

    on_st_e            on_q, on_d;
    off_st_e           off_q, off_d;
    logic [2:0]        fail_q, fail_d;
    logic              tmo_q, tmo_d;
    logic              busy_q, busy_d;
    logic [31:0]       tmr_q, tmr_d;
    logic              tmr_z;
    logic [P_DC_W-1:0] dc;
    logic              aux_open, aux_main, aux_rel;

    assign tmr_z    = (tmr_q == 32'd0);
    assign dc       = bus.i_dc_link;
    assign aux_open = !AUX_CHK || (bus.i_mc_aux == 3'b000);
    assign aux_main = !AUX_CHK || (bus.i_mc_aux == 3'b110);
    assign aux_rel  = !AUX_CHK || (bus.i_mc_aux == 3'b101);

    // Next-state logic for both sequences and the shared timer.
    always_comb begin
        on_d   = on_q;
        off_d  = off_q;
        fail_d = fail_q;
        tmo_d  = tmo_q;
        tmr_d  = tmr_z ? 32'd0 : tmr_q - 32'd1;

        if (on_q != ON_IDLE &&
            (bus.i_op_off_flag || bus.i_intl_flag)) begin
            on_d = ON_IDLE;
        end else begin
            unique case (on_q)
                ON_IDLE: begin
                    if (bus.i_op_on_flag && !bus.i_op_off_flag &&
                        !bus.i_intl_flag && off_q == OFF_IDLE) begin
                        on_d   = ON_OPEN;
                        fail_d = 3'd0;
                    end
                end
                ON_OPEN: begin
                    on_d  = ON_OPEN_W;
                    tmr_d = SETTLE_LD;
                end
                ON_OPEN_W: begin
                    if (tmr_z) begin
                        if (aux_open) begin
                            on_d = ON_PRE;
                        end else begin
                            on_d   = ON_FAIL;
                            fail_d = 3'd1;
                        end
                    end
                end
                ON_PRE: begin
                    on_d  = ON_PRE_W;
                    tmr_d = PRECHG_LD;
                end
                ON_PRE_W: begin
                    if (dc >= bus.i_prechg_lvl) begin
                        on_d = ON_MAIN;
                    end else if (tmr_z) begin
                        on_d   = ON_FAIL;
                        fail_d = 3'd2;
                    end
                end
                ON_MAIN: begin
                    on_d  = ON_MAIN_W;
                    tmr_d = SETTLE_LD;
                end
                ON_MAIN_W: begin
                    if (tmr_z) begin
                        if (aux_main) begin
                            on_d = ON_ALL;
                        end else begin
                            on_d   = ON_FAIL;
                            fail_d = 3'd3;
                        end
                    end
                end
                ON_ALL: begin
                    on_d  = ON_ALL_W;
                    tmr_d = SETTLE_LD;
                end
                ON_ALL_W: begin
                    if (tmr_z) on_d = ON_REL;
                end
                ON_REL: begin
                    on_d  = ON_REL_W;
                    tmr_d = SETTLE_LD;
                end
                ON_REL_W: begin
                    if (tmr_z) begin
                        if (aux_rel) begin
                            on_d = ON_DONE;
                        end else begin
                            on_d   = ON_FAIL;
                            fail_d = 3'd4;
                        end
                    end
                end
                default: on_d = ON_IDLE;
            endcase
        end

        unique case (off_q)
            OFF_IDLE: begin
                if (bus.i_op_off_flag) begin
                    off_d = OFF_OPEN;
                    tmo_d = 1'b0;
                    tmr_d = SETTLE_LD;
                end
            end
            OFF_OPEN: begin
                if (tmr_z) begin
                    off_d = OFF_DIS;
                    tmr_d = DISCHG_LD;
                end
            end
            OFF_DIS: begin
                if (dc <= bus.i_dischg_lvl) begin
                    off_d = OFF_END;
                end else if (tmr_z) begin
                    off_d = OFF_END;
                    tmo_d = 1'b1;
                end
            end
            default: off_d = OFF_IDLE;
        endcase

        busy_d = (on_d != ON_IDLE) || (off_d != OFF_IDLE);
    end

    // State, status and timer registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            on_q   <= ON_IDLE;
            off_q  <= OFF_IDLE;
            fail_q <= 3'd0;
            tmo_q  <= 1'b0;
            busy_q <= 1'b0;
            tmr_q  <= 32'd0;
        end else begin
            on_q   <= on_d;
            off_q  <= off_d;
            fail_q <= fail_d;
            tmo_q  <= tmo_d;
            busy_q <= busy_d;
            tmr_q  <= tmr_d;
        end
    end

    assign bus.o_op_on_fsm  = on_q;
    assign bus.o_op_off_fsm = off_q;
    assign bus.o_fail_code  = fail_q;
    assign bus.o_off_tmo    = tmo_q;
    assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_mps_op_sequencer.sv
// tb_mps_op_sequencer: directed vectors with a scoreboard queue
// and a monitor comparing every cycle after the clock edge.
module tb_mps_op_sequencer;

    localparam int SET = 4;
    localparam int PTO = 20;
    localparam int DTO = 30;

    typedef struct {
        logic [3:0] on;
        logic [3:0] off;
        logic [2:0] fail;
        logic       tmo;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mps_op_sequencer_if #(.P_DC_W(16)) bus();

    mps_op_sequencer #(
        .P_SETTLE_CNT(SET),
        .P_PRECHG_TMO(PTO),
        .P_DISCHG_TMO(DTO),
        .P_DC_W(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    exp_t       sbq[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] cur_on;
    bit         aux_track;
    logic [2:0] aux_fix;
    bit         rst_v;
    bit         intl_v;
    logic [15:0] dc_v;

    int nom[23] = '{2, 2, 2, 2, 3, 4, 5, 6, 6, 6, 6, 9,
                    10, 10, 10, 10, 11, 12, 12, 12, 12, 14, 0};

    function automatic logic [2:0] drv(input logic [3:0] c);
        case (c)
            4'd3, 4'd4:   drv = 3'b100;
            4'd5, 4'd6:   drv = 3'b110;
            4'd9, 4'd10:  drv = 3'b111;
            4'd11, 4'd12: drv = 3'b101;
            default:      drv = 3'b000;
        endcase
    endfunction

    // One stimulus cycle; the expectation is for the following edge.
    task automatic cyc(input bit on_f, input bit off_f,
                       input logic [3:0] e_on, input logic [3:0] e_off,
                       input logic [2:0] e_fail, input bit e_tmo);
        exp_t e;
        @(negedge clk);
        rst               = rst_v;
        bus.i_intl_flag   = intl_v;
        bus.i_dc_link     = dc_v;
        bus.i_op_on_flag  = on_f;
        bus.i_op_off_flag = off_f;
        bus.i_mc_aux      = aux_track ? drv(cur_on) : aux_fix;
        e.on   = e_on;
        e.off  = e_off;
        e.fail = e_fail;
        e.tmo  = e_tmo;
        e.busy = (e_on != 4'd0) || (e_off != 4'd0);
        sbq.push_back(e);
        cur_on = e_on;
    endtask

    // Monitor: pop one expectation per clock edge and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            if (bus.o_op_on_fsm !== e.on || bus.o_op_off_fsm !== e.off ||
                bus.o_fail_code !== e.fail || bus.o_off_tmo !== e.tmo ||
                bus.o_busy !== e.busy) begin
                errors++;
                $display("FAIL chk%0d t=%0t: got on=%0d off=%0d fail=%0d tmo=%0d busy=%0d, want on=%0d off=%0d fail=%0d tmo=%0d busy=%0d",
                         checks, $time, bus.o_op_on_fsm, bus.o_op_off_fsm,
                         bus.o_fail_code, bus.o_off_tmo, bus.o_busy,
                         e.on, e.off, e.fail, e.tmo, e.busy);
            end
        end
    end

    initial begin
        rst = 1'b1;
        rst_v = 1'b1;
        intl_v = 1'b0;
        dc_v = 16'd1000;
        aux_track = 1'b1;
        aux_fix = 3'b000;
        cur_on = 4'd0;
        bus.i_op_on_flag  = 1'b0;
        bus.i_op_off_flag = 1'b0;
        bus.i_intl_flag   = 1'b0;
        bus.i_mc_aux      = 3'b000;
        bus.i_dc_link     = 16'd1000;
        bus.i_prechg_lvl  = 16'd800;
        bus.i_dischg_lvl  = 16'd50;

        // reset state
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        rst_v = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);

        // nominal on sequence
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 23; i++) cyc(0, 0, 4'(nom[i]), 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // precharge timeout
        dc_v = 16'd100;
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 4'(nom[i]), 0, 0, 0);
        for (int i = 0; i < PTO; i++) cyc(0, 0, 4, 0, 0, 0);
        cyc(0, 0, 15, 0, 2, 0);
        cyc(0, 0, 0, 0, 2, 0);

        // aux stuck at 100 during open check
        dc_v = 16'd1000;
        aux_track = 1'b0;
        aux_fix = 3'b100;
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 2, 0, 0, 0);
`ifdef MPS_AUX_CHECK_EN
        cyc(0, 0, 15, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
`else
        for (int i = 4; i < 23; i++) cyc(0, 0, 4'(nom[i]), 0, 0, 0);
`endif
        aux_track = 1'b1;

        // interlock abort in code 6
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 4'(nom[i]), 0, 0, 0);
        intl_v = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        intl_v = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);

        // off request during code 4, then discharge timeout
        dc_v = 16'd100;
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 4'(nom[i]), 0, 0, 0);
        cyc(0, 0, 4, 0, 0, 0);
        cyc(0, 0, 4, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < SET - 1; i++) cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < DTO; i++) cyc(0, 0, 0, 2, 0, 0);
        cyc(0, 0, 0, 3, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // quick discharge clears the timeout flag
        dc_v = 16'd10;
        cyc(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < SET - 1; i++) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 2, 0, 0);
        cyc(0, 0, 0, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // on+off together, then ignored on/off while off busy
        cyc(1, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 2, 0, 0);
        cyc(0, 0, 0, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // synchronous reset during code 9
        dc_v = 16'd1000;
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 4'(nom[i]), 0, 0, 0);
        rst_v = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        rst_v = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mps_op_sequencer.md
# mps_op_sequencer

Power-stage contactor sequencer for the MPS system FSM. On a one-cycle operation-on request it steps the main contactors through open, precharge, main-close and precharge-release, checking DC-link voltage and contactor auxiliary feedback. On an operation-off request it runs the discharge sequence. Progress is published as 4-bit step codes, which the system FSM decodes into contactor drive and its READY/IDLE transitions.

## Interface
- P_SETTLE_CNT, 50000: contactor settle time in clocks (1 ms at 50 MHz).
- P_PRECHG_TMO, 5000000: precharge timeout in clocks.
- P_DISCHG_TMO, 10000000: discharge timeout in clocks.
- P_DC_W, 16: DC-link measurement width.
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_op_on_flag  in  1  one-cycle op-on request.
- i_op_off_flag  in  1  one-cycle op-off request.
- i_intl_flag  in  1  interlock active; level input.
- i_mc_aux  in  3  contactor aux feedback; same bit order as contactor drive.
- i_dc_link  in  P_DC_W  DC-link voltage, unsigned.
- i_prechg_lvl  in  P_DC_W  precharge-complete threshold.
- i_dischg_lvl  in  P_DC_W  discharge-complete threshold.
- o_op_on_fsm  out  4  on-sequence step code.
- o_op_off_fsm  out  4  off-sequence step code.
- o_fail_code  out  3  sticky on-sequence failure cause.
- o_off_tmo  out  1  sticky flag: discharge timed out.
- o_busy  out  1  either sequence is not at code 0.

## Operation
- Two registered state machines share one 32-bit down-timer. The state code is the output code.
- Failure causes: 1 = contactors not open; 2 = precharge timeout; 3 = main-close aux mismatch; 4 = final aux mismatch.
- **On sequence**, codes decoded downstream as contactor drive 1 = 000, 3 = 100, 5 = 110, 9 = 111, 11 = 101:
  - 0 IDLE: on i_op_on_flag, go to 1 and clear o_fail_code.
  - 1: one cycle, then 2.
  - 2: wait P_SETTLE_CNT. Then aux == 000 goes to 3; otherwise 15 with cause 1.
  - 3: one cycle, then 4.
  - 4: when i_dc_link >= i_prechg_lvl, go to 5. If P_PRECHG_TMO elapses first, go to 15 with cause 2.
  - 5: one cycle, then 6.
  - 6: wait P_SETTLE_CNT. Then aux == 110 goes to 9; otherwise 15 with cause 3.
  - 9: one cycle, then 10.
  - 10: wait P_SETTLE_CNT, then 11.
  - 11: one cycle, then 12.
  - 12: wait P_SETTLE_CNT. Then aux == 101 goes to 14; otherwise 15 with cause 4.
  - 14 DONE and 15 FAIL: each held exactly one cycle, then 0.
  - Codes 7, 8 and 13 are never produced.
- **Off sequence**, codes decoded downstream as contactor drive 1 = 100, 2 = 000:
  - 0: on i_op_off_flag, go to 1.
  - 1: wait P_SETTLE_CNT, then 2.
  - 2: when i_dc_link <= i_dischg_lvl, go to 3. If P_DISCHG_TMO elapses first, go to 3 and set o_off_tmo.
  - 3: held one cycle, then 0.
  - Off never fails. o_off_tmo clears on the next i_op_off_flag.
- **Boundary rules:**
  - i_op_off_flag or i_intl_flag while the on sequence is nonzero: on sequence goes to 0 the next cycle, with no 14/15 code and o_fail_code unchanged.
  - i_op_off_flag in that same cycle also starts the off sequence.
  - i_op_on_flag and i_op_off_flag together: off wins; on is ignored.
  - i_op_on_flag while either sequence is nonzero: ignored.
  - i_op_off_flag while off is nonzero: ignored.
  - i_intl_flag does not affect the off sequence.
  - Thresholds are compared unsigned and sampled every cycle.
  - Settle wait expiry and a threshold hit in the same cycle: the threshold wins.

## Timing
- Request flag at clock edge N: code 1 visible after edge N+1.
- Every transition is registered, one edge per step.
- Wait states (2, 6, 10, 12, off 1) last exactly P_SETTLE_CNT cycles.
- The timer is loaded on state entry; expiry is evaluated at count 0.
- Code 4 exits one cycle after the threshold is met.
- Minimum nominal on-sequence length, IDLE to DONE: 4*P_SETTLE_CNT + 7 cycles (threshold already met at entry to 4).
- Reset values: o_op_on_fsm = 0, o_op_off_fsm = 0, o_fail_code = 0, o_off_tmo = 0, o_busy = 0, timer = 0.
- Reset mid-sequence returns all outputs to these values on the next edge.

## Configuration
- MPS_AUX_CHECK_EN defined: aux comparisons at codes 2, 6 and 12 are enforced as specified.
- MPS_AUX_CHECK_EN undefined:
  - i_mc_aux is ignored.
  - Codes 2, 6 and 12 always proceed after the settle time.
  - Causes 1, 3 and 4 are never produced; only precharge timeout can reach 15.

## Test plan
Parameters: P_SETTLE_CNT=4, P_PRECHG_TMO=20, P_DISCHG_TMO=30, macro defined.
- Nominal on: pulse on-flag with aux tracking drive and dc_link=1000 ≥ prechg_lvl=800 -> codes 1,2×4,3,4,5,6×4,9,10×4,11,12×4,14,0; fail_code=0.
- Precharge timeout: dc_link=100 -> code 4 for 20 cycles, then 15 for one cycle, then 0; fail_code=2.
- Aux stuck: aux=100 at end of code 2 -> 15 next cycle; fail_code=1. Rebuild without macro -> sequence reaches 14.
- Abort: intl_flag asserted during code 6 -> code 0 next cycle; fail_code=0. Off-flag during code 4 -> on 0, off 1 same cycle.
- Off: off-flag with dc_link above dischg_lvl=50 for 30 cycles -> codes 1×4, 2×30, 3; off_tmo=1. Repeat with dc_link=10 -> 2 lasts 1 cycle; off_tmo cleared.
- Simultaneous and reset: on-flag and off-flag in the same cycle -> off=1, on=0. Sync reset during code 9 -> all outputs 0 next edge.
